keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad and produces the debounced 5-bit key code consumed by the
//  chronometer/calculator top level, which samples it every clk.
//  Drives rows active-low one at a time and reads active-low pulled-up columns.
//  Presents a level code (T_NULL when idle) plus a one-cycle press strobe.
//  Runs on the 1000 Hz system clock.
// PARAMETERS
//  SETTLE    3   clk cycles each row is driven per scan slot; minimum 3 (2-flop sync + 1)
//  DEBOUNCE  3   consecutive identical full-scan results required to change key_code; min 1
// PORTS
//  clk        in   1  system clock, 1000 Hz; sole clock
//  rst        in   1  synchronous reset, active-high
//  col_n      in   4  keypad columns, active-low, asynchronous to clk
//  row_n      out  4  keypad row drive, one-hot active-low
//  key_code   out  5  debounced key: 0-9 digits, A=0x0A B=0x0B C=0x0C D=0x0D, *=0x0E (T_ASTE),
//                     #=0x0F (T_HASH), none=0x1F (T_NULL)
//  key_press  out  1  one-cycle pulse when key_code changes to a non-NULL value
// BEHAVIOUR
//  Reset: row_n=4'b1110, key_code=0x1F, key_press=0; row index, slot counter, scan
//   accumulator, candidate (=0x1F), debounce count (=0) and sync flops all cleared.
//  Layout: row0 = 1 2 3 A | row1 = 4 5 6 B | row2 = 7 8 9 C | row3 = * 0 # D;
//   column c = col_n[c], left to right.
//  Sync: col_n goes through two flops before use; no logic sees raw col_n.
//  Scan FSM: row index 0..3; each row is driven for SETTLE cycles. On the last cycle of a
//   slot, the synced columns are sampled into the scan accumulator. The row then advances,
//   wrapping 3->0. One full scan is 4*SETTLE cycles (12 at the defaults).
//  Scan result, evaluated at the end of row 3:
//   - exactly one key low in the whole scan -> its code;
//   - no keys low -> 0x1F;
//   - two or more keys low (any rows or columns) -> 0x1F (ghosting rejected).
//   The accumulator clears for the next scan.
//  Debounce:
//   - result == candidate: count increments, saturating at DEBOUNCE;
//   - otherwise: candidate <= result and count <= 1.
//   - The cycle after count reaches DEBOUNCE with candidate != key_code: key_code <= candidate.
//  key_press = 1 for exactly that cycle, only if the new key_code != 0x1F.
//   A held key never re-strobes. Going A -> B directly without NULL strobes for B.
//  Release: key_code returns to 0x1F after DEBOUNCE consecutive empty scans; no strobe.
//  Latency: a stable press is reflected in key_code within (DEBOUNCE+1)*4*SETTLE+3 cycles
//   (51 at defaults). A bounce shorter than one scan never reaches key_code.
//  Reset mid-scan or mid-debounce: everything returns to reset values; key_code=0x1F
//   even if a key is still held. After rst falls, the held key re-strobes once it is
//   debounced again.
//  row_n is always exactly one bit low, including during and immediately after reset.
// TESTING
//  1 rst=1 for 2 cycles -> row_n=1110, key_code=0x1F, key_press=0; rows then cycle
//    1101, 1011, 0111, 1110 every 3 cycles.
//  2 hold '5' (row1/col1) for 80 cycles -> key_code=0x05 within 51 cycles; key_press
//    high exactly 1 cycle; after release key_code=0x1F within 51 cycles with no strobe.
//  3 press '#' (row3/col2), chatter on/off every 5 cycles for 30 cycles, then stable
//    -> key_code goes straight from 0x1F to 0x0F, exactly one key_press.
//  4 hold '1' and '9' together -> key_code stays 0x1F, no strobe. Releasing '9' ->
//    key_code=0x01 with one strobe.
//  5 hold 'D', wait for key_code=0x0D, then slide to '*' with no gap -> key_code=0x0E and
//    a second strobe. Count the press strobes: D,* = 2.
//  6 hold '7' and assert rst for 1 cycle just after key_code=0x07 -> key_code=0x1F next
//    cycle; re-reads 0x07 with a fresh strobe within 51 cycles of rst falling.

Source files
------------

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 matrix keypad one row at a time and presents a debounced key
//   code with a single-cycle press strobe. Rows are driven active-low, columns
//   are read active-low through a two-flop synchroniser. A full scan that sees
//   exactly one closed switch yields that key; an empty scan or a scan with two
//   or more closed switches (ghosting) yields T_NULL. The code only changes
//   after DEBOUNCE identical full-scan results in a row.
//
//   Layout (row r, column c = col_n[c]):
//      row0 = 1 2 3 A | row1 = 4 5 6 B | row2 = 7 8 9 C | row3 = * 0 # D
//
// Parameters
//   SETTLE    clk cycles each row is driven (>= 3: two sync flops + one)
//   DEBOUNCE  identical full-scan results needed to change key_code (>= 1)
//
// Ports
//   clk        in   1  system clock, sole clock
//   rst        in   1  synchronous reset, active-high
//   col_n      in   4  keypad columns, active-low, asynchronous to clk
//   row_n      out  4  row drive, exactly one bit low
//   key_code   out  5  debounced key 0x00-0x0F, 0x1F when no key
//   key_press  out  1  one-cycle pulse when key_code changes to a real key
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SETTLE   = 3,
   parameter int DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [4:0] key_code,
   output logic       key_press
);

   localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int            CW        = $clog2(DEBOUNCE + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SETTLE - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE);
   localparam logic [4:0]    T_NULL    = 5'h1F;

   typedef enum logic [1:0] {
      ROW0 = 2'd0,
      ROW1 = 2'd1,
      ROW2 = 2'd2,
      ROW3 = 2'd3
   } row_state_t;

   row_state_t    r_state;
   row_state_t    w_state_next;
   logic [SW-1:0] r_slot;
   logic [SW-1:0] w_slot_next;
   logic          w_slot_end;
   logic          w_scan_end;
   logic [3:0]    r_row_n;
   logic [3:0]    w_row_n_next;
   logic [3:0]    r_col_s1;
   logic [3:0]    r_col_s2;
   logic [15:0]   r_acc;
   logic [15:0]   w_acc_merged;
   logic [4:0]    w_scan_result;
   logic [4:0]    r_cand;
   logic [CW-1:0] r_count;
   logic [4:0]    r_key_code;
   logic          r_key_press;

   // Key code at accumulator bit position row*4+col.
   function automatic logic [4:0] key_at(input logic [3:0] idx);
      logic [4:0] code;
      case (idx)
         4'd0:    code = 5'h01;
         4'd1:    code = 5'h02;
         4'd2:    code = 5'h03;
         4'd3:    code = 5'h0A;
         4'd4:    code = 5'h04;
         4'd5:    code = 5'h05;
         4'd6:    code = 5'h06;
         4'd7:    code = 5'h0B;
         4'd8:    code = 5'h07;
         4'd9:    code = 5'h08;
         4'd10:   code = 5'h09;
         4'd11:   code = 5'h0C;
         4'd12:   code = 5'h0E;
         4'd13:   code = 5'h00;
         4'd14:   code = 5'h0F;
         4'd15:   code = 5'h0D;
         default: code = T_NULL;
      endcase
      return code;
   endfunction

   // Exactly one closed switch gives its code; none or several give T_NULL.
   function automatic logic [4:0] scan_decode(input logic [15:0] bits);
      logic [4:0] code;
      int         n;
      code = T_NULL;
      n    = 0;
      for (int i = 0; i < 16; i++) begin
         code = bits[i] ? key_at(4'(i)) : code;
         n    = n + int'(bits[i]);
      end
      return (n == 1) ? code : T_NULL;
   endfunction

   // Scan FSM state register: current row and position inside its slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ROW0;
         r_slot  <= {SW{1'b0}};
         r_row_n <= 4'b1110;
      end else begin
         r_state <= w_state_next;
         r_slot  <= w_slot_next;
         r_row_n <= w_row_n_next;
      end
   end

   // Scan FSM next state: advance to the next row after SETTLE cycles.
   always_comb begin
      w_slot_end   = (r_slot == SLOT_LAST);
      w_state_next = r_state;
      w_slot_next  = r_slot;
      if (w_slot_end) begin
         w_slot_next = {SW{1'b0}};
         case (r_state)
            ROW0:    w_state_next = ROW1;
            ROW1:    w_state_next = ROW2;
            ROW2:    w_state_next = ROW3;
            ROW3:    w_state_next = ROW0;
            default: w_state_next = ROW0;
         endcase
      end else begin
         w_slot_next = r_slot + SW'(1);
      end
   end

   // Scan FSM outputs: row drive for the coming cycle, and this row's
   // closed switches merged into the scan accumulator.
   always_comb begin
      w_scan_end = w_slot_end && (r_state == ROW3);
      case (w_state_next)
         ROW0:    w_row_n_next = 4'b1110;
         ROW1:    w_row_n_next = 4'b1101;
         ROW2:    w_row_n_next = 4'b1011;
         ROW3:    w_row_n_next = 4'b0111;
         default: w_row_n_next = 4'b1110;
      endcase
      case (r_state)
         ROW0:    w_acc_merged = r_acc | {12'd0, ~r_col_s2};
         ROW1:    w_acc_merged = r_acc | {8'd0, ~r_col_s2, 4'd0};
         ROW2:    w_acc_merged = r_acc | {4'd0, ~r_col_s2, 8'd0};
         ROW3:    w_acc_merged = r_acc | {~r_col_s2, 12'd0};
         default: w_acc_merged = r_acc;
      endcase
      w_scan_result = scan_decode(w_acc_merged);
   end

   // Two-flop synchroniser for the asynchronous columns; idles at "no key".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col_s1 <= 4'b1111;
         r_col_s2 <= 4'b1111;
      end else begin
         r_col_s1 <= col_n;
         r_col_s2 <= r_col_s1;
      end
   end

   // Scan accumulator: collect each row on its last slot cycle, clear per scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= 16'd0;
      end else if (w_scan_end) begin
         r_acc <= 16'd0;
      end else if (w_slot_end) begin
         r_acc <= w_acc_merged;
      end else begin
         r_acc <= r_acc;
      end
   end

   // Debounce: count consecutive identical scan results, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cand  <= T_NULL;
         r_count <= {CW{1'b0}};
      end else if (w_scan_end) begin
         if (w_scan_result == r_cand) begin
            r_count <= (r_count == CNT_MAX) ? r_count : r_count + CW'(1);
         end else begin
            r_cand  <= w_scan_result;
            r_count <= CW'(1);
         end
      end else begin
         r_cand  <= r_cand;
         r_count <= r_count;
      end
   end

   // Output register: adopt a fully debounced candidate; strobe real keys only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_code  <= T_NULL;
         r_key_press <= 1'b0;
      end else if ((r_count == CNT_MAX) && (r_cand != r_key_code)) begin
         r_key_code  <= r_cand;
         r_key_press <= (r_cand != T_NULL);
      end else begin
         r_key_code  <= r_key_code;
         r_key_press <= 1'b0;
      end
   end

   assign row_n     = r_row_n;
   assign key_code  = r_key_code;
   assign key_press = r_key_press;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner. A keypad model turns the set of held
//   keys into column levels from the driven row. A behavioural model predicts
//   row_n, key_code and key_press from scan timing arithmetic and a history of
//   full-scan results; one process compares every cycle. Directed scenarios add
//   hand-computed literal checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int         SET    = 3;
   localparam int         DEB    = 3;
   localparam logic [4:0] T_NULL = 5'h1F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic [4:0]  key_code;
   logic        key_press;
   logic [15:0] keys = 16'h0000;   // bit row*4+col = key held

   int n_cmp     = 0;
   int n_bad     = 0;
   int press_cnt = 0;

   keypad_scanner #(.SETTLE(SET), .DEBOUNCE(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .col_n     (col_n),
      .row_n     (row_n),
      .key_code  (key_code),
      .key_press (key_press)
   );

   always #5 clk = ~clk;

   // Keypad: a held key pulls its column low while its row is driven low.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
      end
   end

   // ---------------------------------------------------------------- model --
   logic [15:0] keys_at_edge = 16'h0000;
   logic        rst_at_edge  = 1'b1;

   always @(posedge clk) begin
      keys_at_edge <= keys;
      rst_at_edge  <= rst;
   end

   int          m_e;
   logic [15:0] m_cap;
   logic [4:0]  m_hist[$];
   logic [4:0]  exp_code;
   logic        exp_press;
   logic [3:0]  exp_row;
   bit          m_pend;
   logic [4:0]  m_pend_code;

   function automatic logic [4:0] code_of(input int idx);
      string pad;
      int    ch;
      pad = "123A456B789C*0#D";
      ch  = int'(pad.getc(idx));
      if (ch >= 48 && ch <= 57) return 5'(ch - 48);        // '0'..'9'
      if (ch >= 65 && ch <= 68) return 5'(ch - 55);        // 'A'..'D'
      if (ch == 42) return 5'h0E;                          // '*'
      return 5'h0F;                                        // '#'
   endfunction

   function automatic logic [4:0] scan_code(input logic [15:0] bits);
      if ($countones(bits) != 1) return T_NULL;
      for (int i = 0; i < 16; i++) begin
         if (bits[i]) return code_of(i);
      end
      return T_NULL;
   endfunction

   // One model step per posedge; e = edges since reset released.
   task automatic model_step();
      bit same;
      logic [4:0] res;
      if (rst_at_edge) begin
         m_e = 0; m_cap = 16'h0; m_hist.delete();
         exp_code = T_NULL; exp_press = 1'b0; m_pend = 1'b0;
      end else begin
         m_e++;
         exp_press = 1'b0;
         if (m_pend) begin
            exp_code  = m_pend_code;
            exp_press = (m_pend_code != T_NULL);
            m_pend    = 1'b0;
         end
         // Columns of a row are captured by the first sync flop at the edge
         // that ends the first cycle of that row's slot.
         if ((m_e - 1) % SET == 0)
            m_cap[(((m_e - 1) / SET) % 4) * 4 +: 4] = keys_at_edge[(((m_e - 1) / SET) % 4) * 4 +: 4];
         if (m_e % (4 * SET) == 0) begin
            res = scan_code(m_cap);
            m_cap = 16'h0;
            m_hist.push_back(res);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            same = (m_hist.size() == DEB);
            foreach (m_hist[i]) same = same && (m_hist[i] == res);
            if (same && res != exp_code) begin
               m_pend = 1'b1; m_pend_code = res;
            end
         end
      end
      exp_row = ~(4'b0001 << ((m_e / SET) % 4));
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, DUT against model.
   initial begin
      forever begin
         @(negedge clk);
         model_step();
         check("row_n", int'(row_n), int'(exp_row));
         check("key_code", int'(key_code), int'(exp_code));
         check("key_press", int'(key_press), int'(exp_press));
         if (key_press === 1'b1) press_cnt++;
      end
   end

   // ------------------------------------------------------------- stimulus --
   task automatic wait_code(input logic [4:0] target, input int limit, input string name);
      int n;
      n = 0;
      while (key_code !== target && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(key_code), int'(target));
   endtask

   initial begin
      logic [3:0] seq [4];
      int p0;
      seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

      // 1: reset values and row rotation
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t1 reset row_n", int'(row_n), 32'h0000000E);
      check("t1 reset key_code", int'(key_code), 32'h0000001F);
      check("t1 reset key_press", int'(key_press), 0);
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k % 3 == 0) check("t1 row rotation", int'(row_n), int'(seq[k / 3 - 1]));
      end
      repeat (20) @(negedge clk);

      // 2: hold '5', then release
      p0 = press_cnt;
      keys = 16'h0020;
      wait_code(5'h05, 51, "t2 press latency");
      repeat (40) @(negedge clk);
      check("t2 held code", int'(key_code), 5);
      check("t2 one strobe", press_cnt - p0, 1);
      keys = 16'h0000;
      wait_code(T_NULL, 51, "t2 release latency");
      repeat (5) @(negedge clk);
      check("t2 no release strobe", press_cnt - p0, 1);

      // 3: chattering '#', then stable
      p0 = press_cnt;
      for (int i = 0; i < 3; i++) begin
         keys = 16'h4000; repeat (5) @(negedge clk);
         keys = 16'h0000; repeat (5) @(negedge clk);
      end
      keys = 16'h4000;
      wait_code(5'h0F, 51, "t3 hash latency");
      repeat (30) @(negedge clk);
      check("t3 hash code", int'(key_code), 15);
      check("t3 one strobe", press_cnt - p0, 1);
      keys = 16'h0000;
      wait_code(T_NULL, 51, "t3 release");

      // 4: '1' and '9' together are rejected, '1' alone is accepted
      p0 = press_cnt;
      keys = 16'h0401;
      repeat (60) @(negedge clk);
      check("t4 ghost code", int'(key_code), 31);
      check("t4 ghost no strobe", press_cnt - p0, 0);
      keys = 16'h0001;
      wait_code(5'h01, 51, "t4 single latency");
      repeat (3) @(negedge clk);
      check("t4 one strobe", press_cnt - p0, 1);
      keys = 16'h0000;
      wait_code(T_NULL, 51, "t4 release");

      // 5: 'D' slid directly to '*'
      p0 = press_cnt;
      keys = 16'h8000;
      wait_code(5'h0D, 51, "t5 D latency");
      keys = 16'h1000;
      wait_code(5'h0E, 51, "t5 star latency");
      repeat (3) @(negedge clk);
      check("t5 two strobes", press_cnt - p0, 2);
      keys = 16'h0000;
      wait_code(T_NULL, 51, "t5 release");

      // 6: reset while '7' is held, then re-acquire
      p0 = press_cnt;
      keys = 16'h0100;
      wait_code(5'h07, 51, "t6 first latency");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6 code after reset", int'(key_code), 31);
      check("t6 first strobe", press_cnt - p0, 1);
      wait_code(5'h07, 51, "t6 reacquire latency");
      repeat (3) @(negedge clk);
      check("t6 fresh strobe", press_cnt - p0, 2);
      keys = 16'h0000;
      repeat (60) @(negedge clk);
      check("t6 final idle", int'(key_code), 31);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
